conv_result_capture: RTL and testbench
======================================

Name: conv_result_capture

Overview:
- Synthesizable, parametrised result collector for the conv_top output stream (data/valid/running).
- Arms, then captures every valid result while the convolver is running, across CHANNELS parallel lanes.
- Detects end of frame when running_i falls, and holds results in an on-chip buffer readable after completion.
- Keeps a running checksum, sample count and sticky overflow flag for on-chip self-check and host readback.

Parameters:
- DATA_WIDTH, 16, bits per channel sample.
- CHANNELS, 1, parallel lanes sampled on one shared valid.
- DEPTH, 10000, buffer entries (one entry = all lanes); default equals N*N for N=100.
- ADDR_WIDTH, 14, buffer address width; must satisfy 2^ADDR_WIDTH >= DEPTH.
- TIMEOUT_CYCLES, 1024, idle-cycle limit; used only with the optional feature.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- arm_i, input, 1, start a new capture (one-cycle pulse).
- running_i, input, 1, convolver running flag.
- valid_i, input, 1, result valid for all lanes.
- data_i, input, CHANNELS*DATA_WIDTH, lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- rd_en_i, input, 1, buffer read request.
- rd_addr_i, input, ADDR_WIDTH, read address.
- rd_data_o, output, CHANNELS*DATA_WIDTH, read data.
- rd_valid_o, output, 1, read data valid.
- count_o, output, ADDR_WIDTH+1, entries stored.
- checksum_o, output, 32, wrapping sum of stored lane samples.
- busy_o, output, 1, high in WAIT_RUN or CAPTURE.
- done_o, output, 1, high in DONE.
- overflow_o, output, 1, sticky: a sample was dropped because the buffer was full.

Behaviour:
- Reset: clk is the clock; rst is synchronous, active-high. On reset the FSM goes to IDLE and all outputs are 0.
  - Reset mid-capture aborts the capture and clears count, checksum and flags.
  - Buffer contents are not cleared by reset.
- FSM states: IDLE, WAIT_RUN, CAPTURE, DONE.
  - IDLE -> WAIT_RUN on arm_i.
  - WAIT_RUN -> CAPTURE when running_i=1.
  - CAPTURE -> DONE when running_i=0.
  - DONE -> WAIT_RUN on arm_i.
  - arm_i is ignored in WAIT_RUN and CAPTURE.
- Arm action: on the arm transition, count_o, checksum_o and overflow_o clear in the same edge.
- Capture condition: running_i && valid_i, in WAIT_RUN or CAPTURE.
  - The sample present on the WAIT_RUN->CAPTURE edge is captured, so no first sample is lost.
  - valid_i with running_i=0 is never captured.
- Capture action when count_o < DEPTH:
  - buffer[count_o] <= data_i.
  - count_o += 1.
  - checksum_o += sum of all lanes, each zero-extended to 32 bits, modulo 2^32.
  - All three updates are visible the cycle after the edge.
- Full buffer: a capture with count_o == DEPTH drops the sample and sets overflow_o. count_o and checksum_o are unchanged.
- busy_o and done_o are registered decodes of the state.
- Read port: synchronous, latency 1, legal in any state.
  - rd_valid_o = registered rd_en_i.
  - rd_data_o = buffer[rd_addr_i] if rd_addr_i < count_o at the request edge, else 0.
  - rd_data_o holds its value when rd_en_i=0.
- Simultaneous read and write to the same address: the read returns the old contents, or 0 per the count rule.

Optional Feature:
- Macro CAPTURE_TIMEOUT_EN.
- Defined:
  - Adds output timeout_o (1 bit) and an idle counter.
  - The counter clears on any capture and on arm, and increments in WAIT_RUN/CAPTURE otherwise.
  - When it reaches TIMEOUT_CYCLES, the FSM goes to DONE and timeout_o is set (sticky until arm or rst).
- Undefined: no counter, no timeout_o port; WAIT_RUN/CAPTURE wait indefinitely.

Test Plan:
- Basic frame (CHANNELS=1, DEPTH=8): reset, arm, running high 6 cycles with valid on 4 cycles, data 3,5,7,9, then running low.
  - Expect count_o=4, checksum_o=24, done_o=1, busy_o=0.
  - Reads of addr 0..3 give 3,5,7,9 one cycle after rd_en; addr 4 gives 0.
- Overflow (DEPTH=8): 10 valid samples of value 1 during running.
  - Expect count_o=8, checksum_o=8, overflow_o=1; addr 7 reads 1.
- Multichannel (CHANNELS=2): samples {lane1=0xFFFF, lane0=0x0001} x2.
  - Expect checksum_o=0x00020000, count_o=2, rd_data_o=0xFFFF0001.
- Edge cases:
  - valid with running low before arm, and in WAIT_RUN: not captured, count_o=0.
  - Re-arm in DONE clears count/checksum/overflow the next cycle.
  - arm during CAPTURE is ignored.
- Reset mid-capture after 3 samples: state IDLE, count_o=0, done_o=0; a following arm+frame captures from address 0.
- With CAPTURE_TIMEOUT_EN, TIMEOUT_CYCLES=16: arm, no running for 16 cycles.
  - Expect done_o=1, timeout_o=1, count_o=0; re-arm clears timeout_o.

Source files
------------

// File: rtl/conv_result_capture_if.sv
// Handshake/result bus between the conv_top output stream and the result collector.
// timeout_o exists only when CAPTURE_TIMEOUT_EN is defined.
interface conv_result_capture_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 1,
  parameter int ADDR_WIDTH = 14
);
  logic                           arm_i;
  logic                           running_i;
  logic                           valid_i;
  logic [CHANNELS*DATA_WIDTH-1:0] data_i;
  logic                           rd_en_i;
  logic [ADDR_WIDTH-1:0]          rd_addr_i;
  logic [CHANNELS*DATA_WIDTH-1:0] rd_data_o;
  logic                           rd_valid_o;
  logic [ADDR_WIDTH:0]            count_o;
  logic [31:0]                    checksum_o;
  logic                           busy_o;
  logic                           done_o;
  logic                           overflow_o;
`ifdef CAPTURE_TIMEOUT_EN
  logic                           timeout_o;
`endif

  modport master (
    output arm_i, running_i, valid_i, data_i, rd_en_i, rd_addr_i,
`ifdef CAPTURE_TIMEOUT_EN
    input  timeout_o,
`endif
    input  rd_data_o, rd_valid_o, count_o, checksum_o, busy_o, done_o, overflow_o
  );

  modport slave (
    input  arm_i, running_i, valid_i, data_i, rd_en_i, rd_addr_i,
`ifdef CAPTURE_TIMEOUT_EN
    output timeout_o,
`endif
    output rd_data_o, rd_valid_o, count_o, checksum_o, busy_o, done_o, overflow_o
  );
endinterface

// File: rtl/conv_result_capture.sv
// Result collector for the conv_top stream: arm, capture while running, buffer + checksum readback.
// Define CAPTURE_TIMEOUT_EN to add an idle-cycle timeout that forces DONE and raises timeout_o.
module conv_result_capture #(
  parameter int DATA_WIDTH     = 16,
  parameter int CHANNELS       = 1,
  parameter int DEPTH          = 10000,
  parameter int ADDR_WIDTH     = 14,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                  clk,
  input logic                  rst,
  conv_result_capture_if.slave bus
);

  localparam int                  DW      = CHANNELS * DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RUN = 2'd1,
    CAPTURE  = 2'd2,
    DONE     = 2'd3
  } state_t;

  // Sum of all lanes, each zero-extended, wrapping at 32 bits.
  function automatic logic [31:0] lane_sum(input logic [DW-1:0] d);
    logic [31:0] acc;
    acc = 32'd0;
    for (int k = 0; k < CHANNELS; k++) begin
      acc = acc + 32'(d[k*DATA_WIDTH +: DATA_WIDTH]);
    end
    return acc;
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic [31:0]         checksum_q, checksum_d;
  logic                overflow_q, overflow_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DW-1:0]       rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DW-1:0]       mem_q [DEPTH];

  logic                  in_run;
  logic                  arm_take;
  logic                  cap;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  timeout_hit;

`ifdef CAPTURE_TIMEOUT_EN
  localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] IDLE_ONE  = TW'(1);
  logic [TW-1:0] idle_q, idle_d;
  logic          timeout_q, timeout_d;
`endif

  // Next-state, capture bookkeeping and read-port logic.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    checksum_d = checksum_q;
    overflow_d = overflow_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = bus.rd_en_i;
    wr_en      = 1'b0;
    wr_addr    = count_q[ADDR_WIDTH-1:0];

    in_run   = (state_q == WAIT_RUN) || (state_q == CAPTURE);
    arm_take = bus.arm_i && ((state_q == IDLE) || (state_q == DONE));
    cap      = in_run && bus.running_i && bus.valid_i;

`ifdef CAPTURE_TIMEOUT_EN
    timeout_d = timeout_q;
    if (arm_take || cap) begin
      idle_d = '0;
    end else if (in_run) begin
      idle_d = idle_q + IDLE_ONE;
    end else begin
      idle_d = idle_q;
    end
    timeout_hit = in_run && !cap && (idle_d == TIMEOUT_C);
    if (arm_take) begin
      timeout_d = 1'b0;
    end else if (timeout_hit) begin
      timeout_d = 1'b1;
    end else begin
      timeout_d = timeout_q;
    end
`else
    timeout_hit = 1'b0;
`endif

    // A full buffer drops the sample but leaves count and checksum untouched.
    if (arm_take) begin
      count_d    = '0;
      checksum_d = 32'd0;
      overflow_d = 1'b0;
    end else if (cap) begin
      if (count_q < DEPTH_C) begin
        wr_en      = 1'b1;
        count_d    = count_q + CNT_ONE;
        checksum_d = checksum_q + lane_sum(bus.data_i);
      end else begin
        overflow_d = 1'b1;
      end
    end else begin
      count_d = count_q;
    end

    case (state_q)
      IDLE: begin
        if (bus.arm_i) state_d = WAIT_RUN;
        else           state_d = IDLE;
      end
      WAIT_RUN: begin
        if (timeout_hit)        state_d = DONE;
        else if (bus.running_i) state_d = CAPTURE;
        else                    state_d = WAIT_RUN;
      end
      CAPTURE: begin
        if (!bus.running_i || timeout_hit) state_d = DONE;
        else                               state_d = CAPTURE;
      end
      DONE: begin
        if (bus.arm_i) state_d = WAIT_RUN;
        else           state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == WAIT_RUN) || (state_d == CAPTURE);
    done_d = (state_d == DONE);

    // Entries at or beyond the current count read as zero, even if stale data sits there.
    if (bus.rd_en_i) begin
      if ({1'b0, bus.rd_addr_i} < count_q) rd_data_d = mem_q[bus.rd_addr_i];
      else                                 rd_data_d = '0;
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Control and status registers; synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      checksum_q <= 32'd0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
`ifdef CAPTURE_TIMEOUT_EN
      idle_q     <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      checksum_q <= checksum_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
`ifdef CAPTURE_TIMEOUT_EN
      idle_q     <= idle_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  // Result buffer; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= bus.data_i;
    end
  end

  assign bus.rd_data_o  = rd_data_q;
  assign bus.rd_valid_o = rd_valid_q;
  assign bus.count_o    = count_q;
  assign bus.checksum_o = checksum_q;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.overflow_o = overflow_q;
`ifdef CAPTURE_TIMEOUT_EN
  assign bus.timeout_o  = timeout_q;
`endif

endmodule

// File: tb/tb_conv_result_capture.sv
// Directed bench for conv_result_capture: single-lane DEPTH=8 instance and a two-lane instance.
module tb_conv_result_capture;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  conv_result_capture_if #(.DATA_WIDTH(16), .CHANNELS(1), .ADDR_WIDTH(3)) bus1 ();
  conv_result_capture_if #(.DATA_WIDTH(16), .CHANNELS(2), .ADDR_WIDTH(3)) bus2 ();

  conv_result_capture #(
    .DATA_WIDTH(16), .CHANNELS(1), .DEPTH(8), .ADDR_WIDTH(3), .TIMEOUT_CYCLES(16)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  conv_result_capture #(
    .DATA_WIDTH(16), .CHANNELS(2), .DEPTH(8), .ADDR_WIDTH(3), .TIMEOUT_CYCLES(16)
  ) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus on bus1 and wait for the next falling edge.
  task automatic cyc1(input logic r, input logic v, input logic [15:0] d, input logic a);
    bus1.running_i = r;
    bus1.valid_i   = v;
    bus1.data_i    = d;
    bus1.arm_i     = a;
    @(negedge clk);
  endtask

  task automatic cyc2(input logic r, input logic v, input logic [31:0] d, input logic a);
    bus2.running_i = r;
    bus2.valid_i   = v;
    bus2.data_i    = d;
    bus2.arm_i     = a;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus1.busy_o, bus1.done_o, bus1.overflow_o, bus1.rd_valid_o} !== 4'b0000) begin
      $display("FAIL reset_flags got=%b exp=0000", {bus1.busy_o, bus1.done_o, bus1.overflow_o, bus1.rd_valid_o});
      errors++;
    end
    checks++;
    if (bus1.count_o !== 4'd0 || bus1.checksum_o !== 32'd0 || bus1.rd_data_o !== 16'd0) begin
      $display("FAIL reset_values got count=%0d cs=%0d rd=%0d exp=0/0/0", bus1.count_o, bus1.checksum_o, bus1.rd_data_o);
      errors++;
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_frame;
    logic [15:0] exp_rd [5];
    exp_rd = '{16'd3, 16'd5, 16'd7, 16'd9, 16'd0};
    // Valid before arm (with and without running) must not be captured.
    cyc1(1'b0, 1'b1, 16'h0055, 1'b0);
    cyc1(1'b0, 1'b1, 16'h0055, 1'b0);
    cyc1(1'b1, 1'b1, 16'h0066, 1'b0);
    checks++;
    if (bus1.count_o !== 4'd0 || bus1.busy_o !== 1'b0) begin
      $display("FAIL pre_arm got count=%0d busy=%b exp=0/0", bus1.count_o, bus1.busy_o);
      errors++;
    end
    cyc1(1'b0, 1'b0, 16'h0000, 1'b1);
    cyc1(1'b0, 1'b1, 16'h0077, 1'b0);
    cyc1(1'b0, 1'b1, 16'h0077, 1'b0);
    checks++;
    if (bus1.count_o !== 4'd0 || bus1.busy_o !== 1'b1 || bus1.done_o !== 1'b0) begin
      $display("FAIL wait_run_no_cap got count=%0d busy=%b done=%b exp=0/1/0", bus1.count_o, bus1.busy_o, bus1.done_o);
      errors++;
    end
    cyc1(1'b1, 1'b1, 16'd3, 1'b0);
    cyc1(1'b1, 1'b0, 16'd0, 1'b0);
    cyc1(1'b1, 1'b1, 16'd5, 1'b0);
    cyc1(1'b1, 1'b1, 16'd7, 1'b0);
    cyc1(1'b1, 1'b0, 16'd0, 1'b1);
    cyc1(1'b1, 1'b1, 16'd9, 1'b0);
    cyc1(1'b0, 1'b0, 16'd0, 1'b0);
    checks++;
    if (bus1.count_o !== 4'd4 || bus1.checksum_o !== 32'd24) begin
      $display("FAIL basic_count_cs got count=%0d cs=%0d exp=4/24", bus1.count_o, bus1.checksum_o);
      errors++;
    end
    checks++;
    if (bus1.done_o !== 1'b1 || bus1.busy_o !== 1'b0 || bus1.overflow_o !== 1'b0) begin
      $display("FAIL basic_flags got done=%b busy=%b ovf=%b exp=1/0/0", bus1.done_o, bus1.busy_o, bus1.overflow_o);
      errors++;
    end
    for (int i = 0; i < 5; i++) begin
      bus1.rd_en_i   = 1'b1;
      bus1.rd_addr_i = 3'(i);
      @(negedge clk);
      checks++;
      if (bus1.rd_valid_o !== 1'b1 || bus1.rd_data_o !== exp_rd[i]) begin
        $display("FAIL basic_read addr=%0d got valid=%b data=%0d exp=1/%0d", i, bus1.rd_valid_o, bus1.rd_data_o, exp_rd[i]);
        errors++;
      end
    end
    bus1.rd_addr_i = 3'd2;
    @(negedge clk);
    bus1.rd_en_i   = 1'b0;
    bus1.rd_addr_i = 3'd0;
    @(negedge clk);
    checks++;
    if (bus1.rd_valid_o !== 1'b0 || bus1.rd_data_o !== 16'd7) begin
      $display("FAIL read_hold got valid=%b data=%0d exp=0/7", bus1.rd_valid_o, bus1.rd_data_o);
      errors++;
    end
  endtask

  task automatic test_overflow;
    cyc1(1'b0, 1'b0, 16'd0, 1'b1);
    checks++;
    if (bus1.count_o !== 4'd0 || bus1.checksum_o !== 32'd0 || bus1.busy_o !== 1'b1 || bus1.done_o !== 1'b0) begin
      $display("FAIL rearm_clear got count=%0d cs=%0d busy=%b done=%b exp=0/0/1/0", bus1.count_o, bus1.checksum_o, bus1.busy_o, bus1.done_o);
      errors++;
    end
    repeat (10) cyc1(1'b1, 1'b1, 16'd1, 1'b0);
    cyc1(1'b0, 1'b0, 16'd0, 1'b0);
    checks++;
    if (bus1.count_o !== 4'd8 || bus1.checksum_o !== 32'd8 || bus1.overflow_o !== 1'b1 || bus1.done_o !== 1'b1) begin
      $display("FAIL overflow got count=%0d cs=%0d ovf=%b done=%b exp=8/8/1/1", bus1.count_o, bus1.checksum_o, bus1.overflow_o, bus1.done_o);
      errors++;
    end
    bus1.rd_en_i   = 1'b1;
    bus1.rd_addr_i = 3'd7;
    @(negedge clk);
    bus1.rd_en_i = 1'b0;
    checks++;
    if (bus1.rd_data_o !== 16'd1) begin
      $display("FAIL overflow_read7 got=%0d exp=1", bus1.rd_data_o);
      errors++;
    end
    cyc1(1'b0, 1'b0, 16'd0, 1'b1);
    checks++;
    if (bus1.overflow_o !== 1'b0 || bus1.count_o !== 4'd0 || bus1.checksum_o !== 32'd0) begin
      $display("FAIL rearm_ovf_clear got ovf=%b count=%0d cs=%0d exp=0/0/0", bus1.overflow_o, bus1.count_o, bus1.checksum_o);
      errors++;
    end
  endtask

  task automatic test_reset_mid_capture;
    logic [15:0] exp_rd [3];
    exp_rd = '{16'h0044, 16'h0055, 16'h0000};
    cyc1(1'b1, 1'b1, 16'h0011, 1'b0);
    cyc1(1'b1, 1'b1, 16'h0022, 1'b0);
    cyc1(1'b1, 1'b1, 16'h0033, 1'b0);
    checks++;
    if (bus1.count_o !== 4'd3 || bus1.checksum_o !== 32'h66) begin
      $display("FAIL mid_pre_reset got count=%0d cs=%0h exp=3/66", bus1.count_o, bus1.checksum_o);
      errors++;
    end
    rst = 1'b1;
    cyc1(1'b0, 1'b0, 16'd0, 1'b0);
    rst = 1'b0;
    cyc1(1'b0, 1'b0, 16'd0, 1'b0);
    checks++;
    if (bus1.busy_o !== 1'b0 || bus1.done_o !== 1'b0 || bus1.count_o !== 4'd0 || bus1.checksum_o !== 32'd0) begin
      $display("FAIL mid_reset got busy=%b done=%b count=%0d cs=%0d exp=0/0/0/0", bus1.busy_o, bus1.done_o, bus1.count_o, bus1.checksum_o);
      errors++;
    end
    cyc1(1'b0, 1'b0, 16'd0, 1'b1);
    cyc1(1'b1, 1'b1, 16'h0044, 1'b0);
    cyc1(1'b1, 1'b1, 16'h0055, 1'b0);
    cyc1(1'b0, 1'b0, 16'd0, 1'b0);
    checks++;
    if (bus1.count_o !== 4'd2 || bus1.checksum_o !== 32'h99 || bus1.done_o !== 1'b1) begin
      $display("FAIL post_reset_frame got count=%0d cs=%0h done=%b exp=2/99/1", bus1.count_o, bus1.checksum_o, bus1.done_o);
      errors++;
    end
    for (int i = 0; i < 3; i++) begin
      bus1.rd_en_i   = 1'b1;
      bus1.rd_addr_i = 3'(i);
      @(negedge clk);
      checks++;
      if (bus1.rd_data_o !== exp_rd[i]) begin
        $display("FAIL post_reset_read addr=%0d got=%0h exp=%0h", i, bus1.rd_data_o, exp_rd[i]);
        errors++;
      end
    end
    bus1.rd_en_i = 1'b0;
  endtask

  task automatic test_multichannel;
    logic [31:0] exp_rd [3];
    exp_rd = '{32'hFFFF0001, 32'hFFFF0001, 32'h00000000};
    cyc2(1'b0, 1'b0, 32'd0, 1'b1);
    cyc2(1'b1, 1'b1, 32'hFFFF0001, 1'b0);
    cyc2(1'b1, 1'b1, 32'hFFFF0001, 1'b0);
    cyc2(1'b0, 1'b0, 32'd0, 1'b0);
    checks++;
    if (bus2.count_o !== 4'd2 || bus2.checksum_o !== 32'h00020000 || bus2.done_o !== 1'b1) begin
      $display("FAIL multi_count_cs got count=%0d cs=%h done=%b exp=2/00020000/1", bus2.count_o, bus2.checksum_o, bus2.done_o);
      errors++;
    end
    for (int i = 0; i < 3; i++) begin
      bus2.rd_en_i   = 1'b1;
      bus2.rd_addr_i = 3'(i);
      @(negedge clk);
      checks++;
      if (bus2.rd_data_o !== exp_rd[i]) begin
        $display("FAIL multi_read addr=%0d got=%h exp=%h", i, bus2.rd_data_o, exp_rd[i]);
        errors++;
      end
    end
    bus2.rd_en_i = 1'b0;
  endtask

`ifdef CAPTURE_TIMEOUT_EN
  task automatic test_timeout;
    cyc1(1'b0, 1'b0, 16'd0, 1'b1);
    repeat (15) cyc1(1'b0, 1'b0, 16'd0, 1'b0);
    checks++;
    if (bus1.done_o !== 1'b0 || bus1.busy_o !== 1'b1 || bus1.timeout_o !== 1'b0) begin
      $display("FAIL timeout_early got done=%b busy=%b to=%b exp=0/1/0", bus1.done_o, bus1.busy_o, bus1.timeout_o);
      errors++;
    end
    cyc1(1'b0, 1'b0, 16'd0, 1'b0);
    checks++;
    if (bus1.done_o !== 1'b1 || bus1.timeout_o !== 1'b1 || bus1.count_o !== 4'd0) begin
      $display("FAIL timeout_fire got done=%b to=%b count=%0d exp=1/1/0", bus1.done_o, bus1.timeout_o, bus1.count_o);
      errors++;
    end
    cyc1(1'b0, 1'b0, 16'd0, 1'b1);
    checks++;
    if (bus1.timeout_o !== 1'b0 || bus1.busy_o !== 1'b1) begin
      $display("FAIL timeout_rearm got to=%b busy=%b exp=0/1", bus1.timeout_o, bus1.busy_o);
      errors++;
    end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    bus1.arm_i = 1'b0; bus1.running_i = 1'b0; bus1.valid_i = 1'b0;
    bus1.data_i = '0;  bus1.rd_en_i = 1'b0;   bus1.rd_addr_i = '0;
    bus2.arm_i = 1'b0; bus2.running_i = 1'b0; bus2.valid_i = 1'b0;
    bus2.data_i = '0;  bus2.rd_en_i = 1'b0;   bus2.rd_addr_i = '0;
    @(negedge clk);
    test_reset();
    test_basic_frame();
    test_overflow();
    test_reset_mid_capture();
    test_multichannel();
`ifdef CAPTURE_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
